// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: accepts a word on valid/ready and shifts it out one bit per clock,
// with sof/eof marking and GAP idle cycles after each frame. Define PARITY_BIT_EN to append an even-parity bit.
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_x,
  output logic              o_bit_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy
);

`ifdef PARITY_BIT_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int LAST  = FRAME_LEN - 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  // Handshake: a word transfers on a rising edge where i_valid=1 and o_ready=1 (o_ready = state is IDLE).
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [FRAME_LEN-1:0]   r_shift, w_shift_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0]       r_gap, w_gap_nxt;
  logic                   r_x, r_bv, r_sof, r_eof, r_busy;
  logic                   w_x, w_bv, w_sof, w_eof, w_busy;
  logic [FRAME_LEN-1:0]   w_frame;

  // The parity bit always follows the data bits, whichever end goes first.
`ifdef PARITY_BIT_EN
  assign w_frame = (LSB_FIRST != 0) ? {^i_data, i_data} : {i_data, ^i_data};
`else
  assign w_frame = i_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_x         = 1'b0;
    w_bv        = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = (LSB_FIRST != 0) ? (w_frame >> 1) : (w_frame << 1);
          w_x         = (LSB_FIRST != 0) ? w_frame[0] : w_frame[FRAME_LEN-1];
          w_cnt_nxt   = '0;
          w_bv        = 1'b1;
          w_sof       = 1'b1;
          w_eof       = (FRAME_LEN == 1);
          w_busy      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(LAST)) begin
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
            w_busy      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_x         = (LSB_FIRST != 0) ? r_shift[0] : r_shift[FRAME_LEN-1];
          w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
          w_bv        = 1'b1;
          w_eof       = (r_cnt == CNT_W'(LAST - 1));
          w_busy      = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_W'(GAP_LAST)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
          w_busy    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_x     <= 1'b0;
      r_bv    <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_x     <= w_x;
      r_bv    <= w_bv;
      r_sof   <= w_sof;
      r_eof   <= w_eof;
      r_busy  <= w_busy;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_x         = r_x;
  assign o_bit_valid = r_bv;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_busy      = r_busy;

endmodule
